vram_host_port: RTL and testbench

VRAM-side responder for host accesses issued by the host bus interface: it accepts host read/write requests (`hostSelect`/`hostRd`/`hostAddr`/`hostWrData`) and returns `hostRdData`. It arbitrates those requests against display-fetch reads for a single-port, synchronous-read VRAM block. The display path has priority; each host request is latched and serviced exactly once.

---
 rtl/vram_pkg.sv | 15 +
 rtl/vram_host_port_host_req_latch.sv | 77 +++++++
 rtl/vram_host_port.sv | 120 ++++++++++++
 tb/tb_vram_host_port.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_pkg.sv
// Shared widths, default starvation limit and controller state encoding
// for the VRAM host port.
package vram_pkg;

  localparam int VRAM_ADDR_W       = 13;
  localparam int VRAM_DATA_W       = 8;
  localparam int VRAM_STARVE_LIMIT = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PEND   = 2'd1,
    ST_RDWAIT = 2'd2
  } vram_state_e;

endpackage

// File: rtl/vram_host_port_host_req_latch.sv
// Host request capture: hostSelect edge detect, single pending slot and the
// sticky overrun flag for requests that arrive while the slot is occupied.
module host_req_latch
  import vram_pkg::*;
#(
  parameter int ADDR_W = VRAM_ADDR_W,
  parameter int DATA_W = VRAM_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              host_select,
  input  logic              host_rd,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wr_data,
  input  logic              consume,
  output logic              accept,
  output logic              pending,
  output logic              req_rd,
  output logic [ADDR_W-1:0] req_addr,
  output logic [DATA_W-1:0] req_wr_data,
  output logic              overrun
);

  logic              sel_q, sel_d;
  logic              pending_q, pending_d;
  logic              rd_q, rd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              overrun_q, overrun_d;
  logic              capture;

  always_comb begin
    capture   = host_select && !sel_q;
    // the slot frees in the same cycle it is consumed, so a new edge then is kept
    accept    = capture && (!pending_q || consume);
    sel_d     = host_select;
    pending_d = pending_q;
    rd_d      = rd_q;
    addr_d    = addr_q;
    data_d    = data_q;
    overrun_d = overrun_q;
    if (consume) pending_d = 1'b0;
    if (accept) begin
      pending_d = 1'b1;
      rd_d      = host_rd;
      addr_d    = host_addr;
      data_d    = host_wr_data;
    end else if (capture) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q     <= 1'b0;
      pending_q <= 1'b0;
      rd_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      sel_q     <= sel_d;
      pending_q <= pending_d;
      rd_q      <= rd_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      overrun_q <= overrun_d;
    end
  end

  assign pending     = pending_q;
  assign req_rd      = rd_q;
  assign req_addr    = addr_q;
  assign req_wr_data = data_q;
  assign overrun     = overrun_q;

endmodule

// File: rtl/vram_host_port.sv
// Single-port VRAM arbiter: display fetches always win, host requests wait in
// one pending slot. VRAM_HOST_STARVE_GUARD_EN bounds host waiting under load.
module vram_host_port
  import vram_pkg::*;
#(
  parameter int ADDR_W       = VRAM_ADDR_W,
  parameter int DATA_W       = VRAM_DATA_W,
  parameter int STARVE_LIMIT = VRAM_STARVE_LIMIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hostSelect,
  input  logic              hostRd,
  input  logic [ADDR_W-1:0] hostAddr,
  input  logic [DATA_W-1:0] hostWrData,
  output logic [DATA_W-1:0] hostRdData,
  output logic              hostOverrun,
  input  logic              dispReq,
  input  logic [ADDR_W-1:0] dispAddr,
  output logic              dispGrant,
  output logic              dispValid,
  output logic [DATA_W-1:0] dispRdData,
  output logic [ADDR_W-1:0] ramAddr,
  output logic [DATA_W-1:0] ramWrData,
  output logic              ramWe,
  input  logic [DATA_W-1:0] ramRdData
);

  logic              req_accept, req_pending, req_rd;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wr_data;
  logic              consume, in_pend, host_grant, starve;
  vram_state_e       state_q, state_d;
  logic [DATA_W-1:0] host_rd_data_q, host_rd_data_d;
  logic              disp_valid_q, disp_valid_d;

  host_req_latch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_req (
    .clk         (clk),
    .rst         (rst),
    .host_select (hostSelect),
    .host_rd     (hostRd),
    .host_addr   (hostAddr),
    .host_wr_data(hostWrData),
    .consume     (consume),
    .accept      (req_accept),
    .pending     (req_pending),
    .req_rd      (req_rd),
    .req_addr    (req_addr),
    .req_wr_data (req_wr_data),
    .overrun     (hostOverrun)
  );

`ifdef VRAM_HOST_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

  assign starve = (starve_cnt_q == CNT_W'(STARVE_LIMIT));

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!in_pend || host_grant) starve_cnt_d = '0;
    else if (dispReq && !starve) starve_cnt_d = starve_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) starve_cnt_q <= '0;
    else     starve_cnt_q <= starve_cnt_d;
  end
`else
  // never true: without the guard the display always wins
  assign starve = (STARVE_LIMIT < 0);
`endif

  always_comb begin
    in_pend    = (state_q == ST_PEND) && req_pending;
    host_grant = in_pend && (!dispReq || starve);
    dispGrant  = dispReq && !(in_pend && starve);
    ramWe      = host_grant && !req_rd;
    ramAddr    = host_grant ? req_addr : dispAddr;
    ramWrData  = req_wr_data;
    consume    = ramWe || (state_q == ST_RDWAIT);
  end

  always_comb begin
    state_d        = state_q;
    host_rd_data_d = host_rd_data_q;
    disp_valid_d   = dispGrant;
    case (state_q)
      ST_IDLE: if (req_accept) state_d = ST_PEND;
      ST_PEND: begin
        if (host_grant) begin
          if (req_rd) state_d = ST_RDWAIT;
          else        state_d = req_accept ? ST_PEND : ST_IDLE;
        end
      end
      ST_RDWAIT: begin
        host_rd_data_d = ramRdData;
        state_d        = req_accept ? ST_PEND : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      host_rd_data_q <= '0;
      disp_valid_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      host_rd_data_q <= host_rd_data_d;
      disp_valid_q   <= disp_valid_d;
    end
  end

  assign hostRdData = host_rd_data_q;
  assign dispValid  = disp_valid_q;
  assign dispRdData = ramRdData;

endmodule

// File: tb/tb_vram_host_port.sv
// Self-checking bench for vram_host_port: directed scenarios plus random
// traffic against a transaction-level reference model and a VRAM model.
module tb_vram_host_port;

  localparam int LIM = 8;
`ifdef VRAM_HOST_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        hostSelect, hostRd;
  logic [12:0] hostAddr, dispAddr, ramAddr;
  logic [7:0]  hostWrData, hostRdData, dispRdData, ramWrData, ramRdData;
  logic        hostOverrun, dispReq, dispGrant, dispValid, ramWe;
  logic        preset_en;
  logic [12:0] preset_addr;
  logic [7:0]  preset_data;

  vram_host_port #(.ADDR_W(13), .DATA_W(8), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst),
    .hostSelect(hostSelect), .hostRd(hostRd), .hostAddr(hostAddr),
    .hostWrData(hostWrData), .hostRdData(hostRdData), .hostOverrun(hostOverrun),
    .dispReq(dispReq), .dispAddr(dispAddr), .dispGrant(dispGrant),
    .dispValid(dispValid), .dispRdData(dispRdData),
    .ramAddr(ramAddr), .ramWrData(ramWrData), .ramWe(ramWe), .ramRdData(ramRdData)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] init_byte(input logic [12:0] a);
    return a[7:0] ^ {a[12:8], 3'b101};
  endfunction

  // synchronous-read VRAM
  logic [7:0] mem [0:8191];
  bit ram_loaded = 1'b0;
  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < 8192; i++) mem[i] <= init_byte(13'(i));
      ram_loaded <= 1'b1;
    end else if (preset_en) begin
      mem[preset_addr] <= preset_data;
    end
    if (ramWe) mem[ramAddr] <= ramWrData;
    ramRdData <= mem[ramAddr];
  end

  int n_vec = 0;
  int n_miss = 0;
  int we_count = 0;
  int nogrant_count = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model state
  logic [7:0]  ref_mem [0:8191];
  bit          m_pend, m_rd, m_rdwait, m_sel_prev, m_overrun, m_dvalid;
  logic [12:0] m_addr;
  logic [7:0]  m_data, m_rdexp, m_hostrd, m_dexp;
  int          m_cnt;

  task automatic model_step();
    bit starved, host_turn, exp_grant, exp_we, capture, accept;
    if (rst) begin
      m_pend = 0; m_rdwait = 0; m_sel_prev = 0; m_overrun = 0;
      m_dvalid = 0; m_hostrd = 8'h00; m_cnt = 0;
      return;
    end
    starved   = GUARD && (m_cnt >= LIM);
    host_turn = m_pend && (!dispReq || starved);
    exp_grant = dispReq && !(m_pend && starved);
    exp_we    = host_turn && !m_rd;
    chk("ramWe", 32'(ramWe), 32'(exp_we));
    chk("dispGrant", 32'(dispGrant), 32'(exp_grant));
    chk("ramAddr", 32'(ramAddr), 32'(host_turn ? m_addr : dispAddr));
    if (exp_we) chk("ramWrData", 32'(ramWrData), 32'(m_data));
    chk("dispValid", 32'(dispValid), 32'(m_dvalid));
    if (m_dvalid) chk("dispRdData", 32'(dispRdData), 32'(m_dexp));
    chk("hostRdData", 32'(hostRdData), 32'(m_hostrd));
    chk("hostOverrun", 32'(hostOverrun), 32'(m_overrun));
    if (ramWe) we_count++;
    if (dispReq && !dispGrant) nogrant_count++;

    capture    = hostSelect && !m_sel_prev;
    accept     = capture && (!m_pend || exp_we);
    m_sel_prev = hostSelect;
    if (m_rdwait) begin
      m_hostrd = m_rdexp;
      m_rdwait = 0;
    end
    m_dvalid = exp_grant;
    if (exp_grant) m_dexp = ref_mem[dispAddr];
    if (host_turn) begin
      if (m_rd) begin
        m_rdwait = 1;
        m_rdexp  = ref_mem[m_addr];
      end else begin
        ref_mem[m_addr] = m_data;
      end
      m_pend = 0;
      m_cnt  = 0;
    end else if (m_pend) begin
      m_cnt = (m_cnt < LIM) ? m_cnt + 1 : LIM;
    end else begin
      m_cnt = 0;
    end
    if (accept) begin
      m_pend = 1; m_rd = hostRd; m_addr = hostAddr; m_data = hostWrData; m_cnt = 0;
    end else if (capture) begin
      m_overrun = 1;
    end
    if (preset_en) ref_mem[preset_addr] = preset_data;
  endtask

  task automatic cyc();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic host_req(input bit rd, input logic [12:0] a, input logic [7:0] d);
    hostSelect = 1'b1; hostRd = rd; hostAddr = a; hostWrData = d;
  endtask

  int we0, ng0;

  initial begin
    for (int i = 0; i < 8192; i++) ref_mem[i] = init_byte(13'(i));
    m_rd = 0; m_addr = '0; m_data = '0; m_rdexp = '0; m_dexp = '0;
    rst = 1'b1; hostSelect = 1'b0; hostRd = 1'b0; hostAddr = '0; hostWrData = '0;
    dispReq = 1'b1; dispAddr = 13'h0042;
    preset_en = 1'b0; preset_addr = '0; preset_data = '0;
    repeat (3) cyc();
    chk("rst_hostRdData", 32'(hostRdData), 32'h0);
    chk("rst_overrun", 32'(hostOverrun), 32'h0);
    chk("rst_dispValid", 32'(dispValid), 32'h0);
    chk("rst_ramWe", 32'(ramWe), 32'h0);
    rst = 1'b0; dispReq = 1'b0;
    cyc();

    // uncontended write held high for several cycles
    we0 = we_count;
    host_req(1'b0, 13'h0123, 8'hA5);
    repeat (4) cyc();
    hostSelect = 1'b0;
    repeat (2) cyc();
    chk("wr_once", 32'(we_count - we0), 32'd1);

    // uncontended read of a preset location
    preset_en = 1'b1; preset_addr = 13'h1ABC; preset_data = 8'h3C;
    cyc();
    preset_en = 1'b0;
    host_req(1'b1, 13'h1ABC, 8'h00);
    repeat (2) cyc();
    hostSelect = 1'b0;
    repeat (3) cyc();
    chk("rd_data", 32'(hostRdData), 32'h3C);
    repeat (3) cyc();
    chk("rd_hold", 32'(hostRdData), 32'h3C);

    // one-cycle write pulse under 20 cycles of display load
    we0 = we_count; ng0 = nogrant_count;
    dispReq = 1'b1;
    host_req(1'b0, 13'h0456, 8'h5A);
    cyc();
    hostSelect = 1'b0;
    for (int i = 0; i < 19; i++) begin
      dispAddr = 13'($urandom);
      cyc();
    end
    dispReq = 1'b0;
    repeat (3) cyc();
    chk("starve_nogrant", 32'(nogrant_count - ng0), GUARD ? 32'd1 : 32'd0);
    chk("starve_wr", 32'(we_count - we0), 32'd1);

    // second edge while the first is still waiting
    chk("ovr_clear", 32'(hostOverrun), 32'h0);
    we0 = we_count;
    dispReq = 1'b1;
    host_req(1'b0, 13'h0777, 8'h11);
    cyc();
    hostSelect = 1'b0;
    cyc();
    host_req(1'b0, 13'h0888, 8'h22);
    cyc();
    hostSelect = 1'b0;
    repeat (2) cyc();
    chk("ovr_set", 32'(hostOverrun), 32'h1);
    dispReq = 1'b0;
    repeat (4) cyc();
    chk("ovr_one_write", 32'(we_count - we0), 32'd1);
    chk("ovr_sticky", 32'(hostOverrun), 32'h1);

    // random traffic
    for (int c = 0; c < 1500; c++) begin
      hostRd     = 1'($urandom_range(0, 1));
      hostAddr   = 13'($urandom);
      hostWrData = 8'($urandom);
      if ($urandom_range(0, 3) == 0) hostSelect = ~hostSelect;
      dispReq  = ((c % 200) < 100) ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 3);
      dispAddr = 13'($urandom);
      cyc();
    end
    hostSelect = 1'b0; dispReq = 1'b0;
    repeat (4) cyc();

    // asynchronous reset with a write waiting behind the display
    dispReq = 1'b1;
    host_req(1'b0, 13'h0999, 8'h77);
    cyc();
    hostSelect = 1'b0;
    cyc();
    #2 rst = 1'b1;
    #1;
    chk("arst_ramWe", 32'(ramWe), 32'h0);
    chk("arst_dispValid", 32'(dispValid), 32'h0);
    chk("arst_hostRdData", 32'(hostRdData), 32'h0);
    chk("arst_overrun", 32'(hostOverrun), 32'h0);
    we0 = we_count;
    dispReq = 1'b0;
    repeat (2) cyc();
    rst = 1'b0;
    repeat (5) cyc();
    chk("arst_no_write", 32'(we_count - we0), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
